// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator scheduler: car command encodings,
// scheduler FSM states and the default floor count.
package elevator_pkg;

  localparam logic [1:0] STOP = 2'b00;
  localparam logic [1:0] UP   = 2'b11;
  localparam logic [1:0] DOWN = 2'b01;

  localparam int unsigned NUM_FLOORS_DEFAULT = 5;

  typedef enum logic [1:0] {
    IDLE,
    MOVE_UP,
    MOVE_DOWN,
    DOOR
  } sched_state_e;

endpackage

// File: rtl/elevator_scheduler_if.sv
// Scheduler <-> car/button bundle. FireRecall exists only when FIRE_RECALL_EN
// is defined.
interface elevator_scheduler_if
  import elevator_pkg::*;
#(
  parameter int unsigned NUM_FLOORS = NUM_FLOORS_DEFAULT,
  parameter int unsigned FLOOR_W    = 5
);

  logic [NUM_FLOORS-1:0] CallReq;
  logic [FLOOR_W-1:0]    CurFloor;
  logic [1:0]            State;
  logic [NUM_FLOORS-1:0] Pending;
  logic                  DoorOpen;
  logic                  DirUp;
`ifdef FIRE_RECALL_EN
  logic                  FireRecall;

  modport master (
    input  CallReq,
    input  CurFloor,
    input  FireRecall,
    output State,
    output Pending,
    output DoorOpen,
    output DirUp
  );

  modport slave (
    output CallReq,
    output CurFloor,
    output FireRecall,
    input  State,
    input  Pending,
    input  DoorOpen,
    input  DirUp
  );
`else
  modport master (
    input  CallReq,
    input  CurFloor,
    output State,
    output Pending,
    output DoorOpen,
    output DirUp
  );

  modport slave (
    output CallReq,
    output CurFloor,
    input  State,
    input  Pending,
    input  DoorOpen,
    input  DirUp
  );
`endif

endinterface

// File: rtl/elevator_call_latch.sv
// Per-floor call register (clear beats set) plus the above/below/here
// reductions relative to the current floor.
module elevator_call_latch
  import elevator_pkg::*;
#(
  parameter int unsigned NUM_FLOORS = NUM_FLOORS_DEFAULT,
  parameter int unsigned FLOOR_W    = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NUM_FLOORS-1:0] set_i,
  input  logic [NUM_FLOORS-1:0] clr_i,
  input  logic [FLOOR_W-1:0]    cur_floor_i,
  output logic [NUM_FLOORS-1:0] pending_o,
  output logic [NUM_FLOORS-1:0] floor_mask_o,
  output logic                  above_o,
  output logic                  below_o,
  output logic                  here_o
);

  logic [NUM_FLOORS-1:0] pending_q, pending_d;

  always_comb begin
    pending_d = (pending_q | set_i) & ~clr_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  // An out-of-range floor yields an empty mask, so nothing reads as "here".
  always_comb begin
    floor_mask_o = '0;
    above_o      = 1'b0;
    below_o      = 1'b0;
    for (int unsigned j = 0; j < NUM_FLOORS; j++) begin
      if (32'(cur_floor_i) == j) floor_mask_o[j] = 1'b1;
      if (32'(cur_floor_i) < j)  above_o = above_o | pending_q[j];
      if (32'(cur_floor_i) > j)  below_o = below_o | pending_q[j];
    end
    here_o = |(pending_q & floor_mask_o);
  end

  assign pending_o = pending_q;

endmodule

// File: rtl/elevator_scheduler.sv
// SCAN-style elevator sequencer: latches calls, steers the car up/down and
// dwells with the door open at each served floor. Optional FIRE_RECALL_EN.
module elevator_scheduler
  import elevator_pkg::*;
#(
  parameter int unsigned NUM_FLOORS   = NUM_FLOORS_DEFAULT,
  parameter int unsigned DWELL_CYCLES = 4,
  parameter int unsigned FLOOR_W      = 5
) (
  input  logic                 Clk,
  input  logic                 Reset,
  elevator_scheduler_if.master bus
);

  localparam int unsigned CntW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CntW-1:0] DwellLoad = CntW'(DWELL_CYCLES - 1);

  sched_state_e fsm_q, fsm_d, idle_next;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic dir_q, dir_d;

  logic [NUM_FLOORS-1:0] set_mask, clr_mask, floor_mask, pending;
  logic above, below, here;
  logic in_range, at_top, at_bottom, reopen;

  elevator_call_latch #(
    .NUM_FLOORS (NUM_FLOORS),
    .FLOOR_W    (FLOOR_W)
  ) u_call_latch (
    .clk_i        (Clk),
    .rst_i        (Reset),
    .set_i        (set_mask),
    .clr_i        (clr_mask),
    .cur_floor_i  (bus.CurFloor),
    .pending_o    (pending),
    .floor_mask_o (floor_mask),
    .above_o      (above),
    .below_o      (below),
    .here_o       (here)
  );

  assign in_range  = 32'(bus.CurFloor) < NUM_FLOORS;
  assign at_top    = 32'(bus.CurFloor) == NUM_FLOORS - 1;
  assign at_bottom = bus.CurFloor == '0;

  // Idle decision, also taken on the door's exit edge.
  always_comb begin
    idle_next = IDLE;
    if (here) begin
      idle_next = DOOR;
    end else if (dir_q) begin
      if (above)      idle_next = MOVE_UP;
      else if (below) idle_next = MOVE_DOWN;
    end else begin
      if (below)      idle_next = MOVE_DOWN;
      else if (above) idle_next = MOVE_UP;
    end
  end

`ifdef FIRE_RECALL_EN
  logic fire_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      fire_q <= 1'b0;
    end else begin
      fire_q <= bus.FireRecall;
    end
  end
`endif

  always_comb begin
    fsm_d    = fsm_q;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    set_mask = bus.CallReq;
    clr_mask = '0;
    reopen   = (fsm_q == DOOR) && |(bus.CallReq & floor_mask);

    // A press at the open floor restarts the dwell instead of latching.
    if (fsm_q == DOOR) set_mask = bus.CallReq & ~floor_mask;

    unique case (fsm_q)
      IDLE: fsm_d = idle_next;
      MOVE_UP: begin
        if (here)                 fsm_d = DOOR;
        else if (!above || at_top) fsm_d = IDLE;
      end
      MOVE_DOWN: begin
        if (here)                     fsm_d = DOOR;
        else if (!below || at_bottom) fsm_d = IDLE;
      end
      DOOR: begin
        if (reopen)              cnt_d = DwellLoad;
        else if (cnt_q == '0)    fsm_d = idle_next;
        else                     cnt_d = cnt_q - CntW'(1);
      end
      default: fsm_d = IDLE;
    endcase

    if (fsm_d == DOOR && fsm_q != DOOR) begin
      clr_mask = floor_mask;
      cnt_d    = DwellLoad;
    end

    if (fsm_d == MOVE_UP)        dir_d = 1'b1;
    else if (fsm_d == MOVE_DOWN) dir_d = 1'b0;

`ifdef FIRE_RECALL_EN
    if (bus.FireRecall) begin
      set_mask = '0;
      clr_mask = '1;
      cnt_d    = DwellLoad;
      if (at_bottom) begin
        fsm_d = DOOR;
      end else begin
        fsm_d = MOVE_DOWN;
        dir_d = 1'b0;
      end
    end else if (fire_q) begin
      fsm_d = IDLE;
    end
`endif

    // Unknown floor: park the car but keep the calls.
    if (!in_range) begin
      fsm_d = IDLE;
      dir_d = dir_q;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      fsm_q <= IDLE;
      cnt_q <= '0;
      dir_q <= 1'b1;
    end else begin
      fsm_q <= fsm_d;
      cnt_q <= cnt_d;
      dir_q <= dir_d;
    end
  end

  always_comb begin
    case (fsm_q)
      MOVE_UP:   bus.State = UP;
      MOVE_DOWN: bus.State = DOWN;
      default:   bus.State = STOP;
    endcase
  end

  assign bus.DoorOpen = (fsm_q == DOOR);
  assign bus.DirUp    = dir_q;
  assign bus.Pending  = pending;

endmodule

// File: tb/tb_elevator_scheduler.sv
// Directed bench for elevator_scheduler with a falling-edge car model.
module tb_elevator_scheduler;
  import elevator_pkg::*;

  localparam int unsigned NF = 5;
  localparam int unsigned DW = 4;
  localparam int unsigned FW = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  elevator_scheduler_if #(.NUM_FLOORS(NF), .FLOOR_W(FW)) bus ();

  elevator_scheduler #(
    .NUM_FLOORS   (NF),
    .DWELL_CYCLES (DW),
    .FLOOR_W      (FW)
  ) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus)
  );

  // Car model: moves one floor per falling edge; force_en teleports it.
  logic [FW-1:0] car;
  logic          force_en;
  logic [FW-1:0] force_val;

  always @(negedge clk) begin
    if (force_en)               car <= force_val;
    else if (bus.State == UP)   car <= car + FW'(1);
    else if (bus.State == DOWN) car <= car - FW'(1);
  end

  assign bus.CurFloor = car;

  logic [13:0] obs;
  assign obs = {bus.State, bus.DoorOpen, bus.DirUp, bus.Pending, bus.CurFloor};

  int n_pass  = 0;
  int n_total = 0;

  function automatic logic [13:0] mk(input logic [1:0] s, input logic d, input logic u,
                                     input logic [4:0] p, input logic [4:0] f);
    return {s, d, u, p, f};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic teleport(input logic [FW-1:0] f);
    force_en  = 1'b1;
    force_val = f;
    @(negedge clk);
    #1;
    force_en = 1'b0;
  endtask

  task automatic test_reset();
    logic [13:0] exp_v;
    rst         = 1'b1;
    bus.CallReq = '1;
    force_en    = 1'b1;
    force_val   = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      exp_v = mk(STOP, 1'b0, 1'b1, 5'b00000, 5'd0);
      n_total++;
      // Floor is not yet defined before the first falling edge.
      if (obs[13:5] !== exp_v[13:5])
        $display("FAIL reset[%0d]: got %b want %b", i, obs[13:5], exp_v[13:5]);
      else n_pass++;
    end
    rst         = 1'b0;
    bus.CallReq = '0;
    force_en    = 1'b0;
  endtask

  task automatic test_single_call();
    logic [13:0] exp_t [9];
    exp_t = '{mk(STOP, 1'b0, 1'b1, 5'b01000, 5'd0), mk(UP, 1'b0, 1'b1, 5'b01000, 5'd0),
              mk(UP, 1'b0, 1'b1, 5'b01000, 5'd1),   mk(UP, 1'b0, 1'b1, 5'b01000, 5'd2),
              mk(STOP, 1'b1, 1'b1, 5'b00000, 5'd3), mk(STOP, 1'b1, 1'b1, 5'b00000, 5'd3),
              mk(STOP, 1'b1, 1'b1, 5'b00000, 5'd3), mk(STOP, 1'b1, 1'b1, 5'b00000, 5'd3),
              mk(STOP, 1'b0, 1'b1, 5'b00000, 5'd3)};
    bus.CallReq = 5'b01000;
    for (int i = 0; i < 9; i++) begin
      tick();
      bus.CallReq = '0;
      n_total++;
      if (obs !== exp_t[i]) $display("FAIL single_call[%0d]: got %b want %b", i, obs, exp_t[i]);
      else n_pass++;
    end
  endtask

  task automatic test_scan_reverse();
    logic [13:0] exp_t [15];
    exp_t = '{mk(STOP, 1'b0, 1'b1, 5'b10010, 5'd2), mk(UP, 1'b0, 1'b1, 5'b10010, 5'd2),
              mk(UP, 1'b0, 1'b1, 5'b10010, 5'd3),   mk(STOP, 1'b1, 1'b1, 5'b00010, 5'd4),
              mk(STOP, 1'b1, 1'b1, 5'b00010, 5'd4), mk(STOP, 1'b1, 1'b1, 5'b00010, 5'd4),
              mk(STOP, 1'b1, 1'b1, 5'b00010, 5'd4), mk(DOWN, 1'b0, 1'b0, 5'b00010, 5'd4),
              mk(DOWN, 1'b0, 1'b0, 5'b00010, 5'd3), mk(DOWN, 1'b0, 1'b0, 5'b00010, 5'd2),
              mk(STOP, 1'b1, 1'b0, 5'b00000, 5'd1), mk(STOP, 1'b1, 1'b0, 5'b00000, 5'd1),
              mk(STOP, 1'b1, 1'b0, 5'b00000, 5'd1), mk(STOP, 1'b1, 1'b0, 5'b00000, 5'd1),
              mk(STOP, 1'b0, 1'b0, 5'b00000, 5'd1)};
    teleport(5'd2);
    bus.CallReq = 5'b10010;
    for (int i = 0; i < 15; i++) begin
      tick();
      bus.CallReq = '0;
      n_total++;
      if (obs !== exp_t[i]) $display("FAIL scan_reverse[%0d]: got %b want %b", i, obs, exp_t[i]);
      else n_pass++;
    end
  endtask

  task automatic test_door_reopen();
    logic [13:0] exp_t [8];
    exp_t = '{mk(STOP, 1'b0, 1'b0, 5'b00100, 5'd2), mk(STOP, 1'b1, 1'b0, 5'b00000, 5'd2),
              mk(STOP, 1'b1, 1'b0, 5'b00000, 5'd2), mk(STOP, 1'b1, 1'b0, 5'b00000, 5'd2),
              mk(STOP, 1'b1, 1'b0, 5'b00000, 5'd2), mk(STOP, 1'b1, 1'b0, 5'b00000, 5'd2),
              mk(STOP, 1'b1, 1'b0, 5'b00000, 5'd2), mk(STOP, 1'b0, 1'b0, 5'b00000, 5'd2)};
    teleport(5'd2);
    for (int i = 0; i < 8; i++) begin
      bus.CallReq = (i == 0 || i == 3) ? 5'b00100 : 5'b00000;
      tick();
      n_total++;
      if (obs !== exp_t[i]) $display("FAIL door_reopen[%0d]: got %b want %b", i, obs, exp_t[i]);
      else n_pass++;
    end
    bus.CallReq = '0;
  endtask

  task automatic test_boundaries();
    logic [13:0] exp_t [16];
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_total++;
    if (obs !== mk(STOP, 1'b0, 1'b1, 5'b00000, 5'd2))
      $display("FAIL boundary_reset: got %b want %b", obs, mk(STOP, 1'b0, 1'b1, 5'b00000, 5'd2));
    else n_pass++;
    exp_t = '{mk(STOP, 1'b0, 1'b1, 5'b10001, 5'd2), mk(UP, 1'b0, 1'b1, 5'b10001, 5'd2),
              mk(UP, 1'b0, 1'b1, 5'b10001, 5'd3),   mk(STOP, 1'b1, 1'b1, 5'b00001, 5'd4),
              mk(STOP, 1'b1, 1'b1, 5'b00001, 5'd4), mk(STOP, 1'b1, 1'b1, 5'b00001, 5'd4),
              mk(STOP, 1'b1, 1'b1, 5'b00001, 5'd4), mk(DOWN, 1'b0, 1'b0, 5'b00001, 5'd4),
              mk(DOWN, 1'b0, 1'b0, 5'b00001, 5'd3), mk(DOWN, 1'b0, 1'b0, 5'b00001, 5'd2),
              mk(DOWN, 1'b0, 1'b0, 5'b00001, 5'd1), mk(STOP, 1'b1, 1'b0, 5'b00000, 5'd0),
              mk(STOP, 1'b1, 1'b0, 5'b00000, 5'd0), mk(STOP, 1'b1, 1'b0, 5'b00000, 5'd0),
              mk(STOP, 1'b1, 1'b0, 5'b00000, 5'd0), mk(STOP, 1'b0, 1'b0, 5'b00000, 5'd0)};
    bus.CallReq = 5'b10001;
    for (int i = 0; i < 16; i++) begin
      tick();
      bus.CallReq = '0;
      n_total++;
      if (obs !== exp_t[i]) $display("FAIL boundaries[%0d]: got %b want %b", i, obs, exp_t[i]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_move();
    bus.CallReq = 5'b01000;
    tick();
    bus.CallReq = '0;
    tick();
    @(negedge clk);
    #1;
    n_total++;
    if (obs !== mk(UP, 1'b0, 1'b1, 5'b01000, 5'd1))
      $display("FAIL mid_move_pre: got %b want %b", obs, mk(UP, 1'b0, 1'b1, 5'b01000, 5'd1));
    else n_pass++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_total++;
      if (obs !== mk(STOP, 1'b0, 1'b1, 5'b00000, 5'd1))
        $display("FAIL mid_move_reset[%0d]: got %b want %b", i, obs,
                 mk(STOP, 1'b0, 1'b1, 5'b00000, 5'd1));
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_floor_fault();
    logic [13:0] exp_v;
    teleport(5'd7);
    bus.CallReq = 5'b00010;
    tick();
    bus.CallReq = '0;
    for (int i = 0; i < 3; i++) begin
      exp_v = mk(STOP, 1'b0, 1'b1, 5'b00010, 5'd7);
      n_total++;
      if (obs !== exp_v) $display("FAIL floor_fault[%0d]: got %b want %b", i, obs, exp_v);
      else n_pass++;
      if (i < 2) tick();
    end
    teleport(5'd1);
    tick();
    exp_v = mk(STOP, 1'b1, 1'b1, 5'b00000, 5'd1);
    n_total++;
    if (obs !== exp_v) $display("FAIL floor_recover: got %b want %b", obs, exp_v);
    else n_pass++;
  endtask

  initial begin
    force_en    = 1'b0;
    force_val   = '0;
    bus.CallReq = '0;
    rst         = 1'b1;
    test_reset();
    test_single_call();
    test_scan_reverse();
    test_door_reopen();
    test_boundaries();
    test_reset_mid_move();
    test_floor_fault();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/elevator_scheduler.md
Name: elevator_scheduler

Overview:
- Sequencing controller for the elevator car model. Drives the car's 2-bit State command (Stop=00, Up=11, Down=01) and consumes its binary current-floor output.
- Latches floor call buttons and serves them SCAN-style: keeps the current direction while calls remain ahead, then reverses.
- Opens the door for a fixed dwell time at each served floor.
- The car model advances one floor per Clk cycle on the falling edge while State=Up/Down. This block is registered on the rising edge, so each floor change is observed before the next command is issued.

Parameters:
- NUM_FLOORS, 5, number of floors (0..NUM_FLOORS-1); sets the CallReq/Pending width.
- DWELL_CYCLES, 4, cycles the door stays open per stop (>=1).
- FLOOR_W, 5, width of the CurFloor input.

Ports:
- Clk  in  1  clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- CallReq  in  NUM_FLOORS  one bit per floor; a 1 sampled on a rising edge registers a call.
- CurFloor  in  FLOOR_W  binary current floor from the car model.
- State  out  2  car command: 00 Stop, 11 Up, 01 Down (10 never driven).
- Pending  out  NUM_FLOORS  latched, unserved calls.
- DoorOpen  out  1  high while dwelling at a floor.
- DirUp  out  1  current/last travel direction; 1=up.

Behaviour:
- Reset values: State=00, Pending=0, DoorOpen=0, DirUp=1, FSM=IDLE, dwell counter=0.
- Reset asserted mid-move: State=00 from the next edge; the car stays at its floor; all calls are dropped.
- Call latch: Pending[i] <= Pending[i] | CallReq[i] every edge, except the clear rules below. Latency: CallReq to Pending is 1 cycle.
- FSM states: IDLE, MOVE_UP, MOVE_DOWN, DOOR. All decisions use the registered Pending, never the raw CallReq.
- "above" = any Pending[j] with j > CurFloor. "below" = any Pending[j] with j < CurFloor. "here" = Pending[CurFloor].
- IDLE (State=00): decide in this priority order.
  - here: go to DOOR.
  - DirUp=1: above -> MOVE_UP, else below -> MOVE_DOWN.
  - DirUp=0: below -> MOVE_DOWN, else above -> MOVE_UP.
  - otherwise stay in IDLE.
- MOVE_UP (State=11, DirUp=1): each edge evaluate the new CurFloor.
  - here: go to DOOR with State=00 on that same edge, so there is no overshoot.
  - no here and no above: go to IDLE.
- MOVE_DOWN: mirror of MOVE_UP with State=01 and DirUp=0.
- DOOR (State=00, DoorOpen=1):
  - On entry, clear Pending[CurFloor] and load the counter with DWELL_CYCLES-1.
  - The state lasts exactly DWELL_CYCLES cycles, then applies the IDLE decision on its exit edge.
- Simultaneous events:
  - CallReq[CurFloor] during DOOR is not latched and reloads the dwell counter (door reopen).
  - A set and a clear of the same bit on the same edge: clear wins.
- Boundaries:
  - Never drive Up at CurFloor=NUM_FLOORS-1 or Down at CurFloor=0. If reached, force State=00 and go to IDLE.
  - CurFloor >= NUM_FLOORS is a fault: State=00, FSM held in IDLE, Pending retained.
- Example timing: car at floor 0, CallReq[3] at edge n.
  - Edge n+1: Pending=01000.
  - Edge n+2: State=11.
  - Edge n+5: CurFloor=3, State=00, DoorOpen=1, Pending=0.
  - Edges n+5..n+8: DoorOpen high.
  - Edge n+9: IDLE.

Optional Feature:
- Macro FIRE_RECALL_EN. When defined, adds input FireRecall (1 bit).
- While FireRecall=1:
  - Pending is cleared and CallReq is ignored.
  - The car is driven to floor 0 (State=01 until CurFloor=0, then State=00).
  - DoorOpen=1 is held at floor 0 with no dwell timeout.
  - On release, the FSM goes to IDLE.
- Without the macro: no port and no logic.

Decomposition:
- Package elevator_pkg holds:
  - the STOP/UP/DOWN 2-bit localparams;
  - the sched_state_e enum (IDLE, MOVE_UP, MOVE_DOWN, DOOR);
  - the default NUM_FLOORS.
- Sub-module elevator_call_latch: per-floor set/clear register, plus the above/below/here reduction given CurFloor.

Test Plan:
- Reset with CallReq=11111 held -> State=00, Pending=00000, DoorOpen=0 on every reset cycle.
- Car at 0, CallReq[3] pulse at edge n -> State=11 at n+2, State=00 and DoorOpen=1 at n+5, Pending=0, DoorOpen low at n+9.
- Car at 2 moving up toward call at 4, CallReq[1] at the same time -> stops at 4 first, then DirUp=0, State=01 down to 1, door opens.
- During DOOR at floor 2, CallReq[2] pulse at dwell cycle 3 -> DoorOpen extends to DWELL_CYCLES cycles after the pulse; Pending[2] stays 0.
- Calls at 0 and 4 latched on the same edge from floor 2, DirUp=1 -> serves 4 then 0. State never shows 11 at floor 4 or 01 at floor 0.
- Reset asserted while State=11 at floor 1 -> State=00 next edge, CurFloor stays 1, Pending=0.
